acc_record_transmitter: RTL and testbench

Reads accumulated 16-bit histogram words from the data-transfer FIFO on the capture side and serializes them as framed byte records onto the host byte link (UART/FT245 transmit path). Sits between the capture/accumulator block and the byte transmitter, in the capture block's slow clock domain. It drives the read end of the FIFO (read strobe, valid, not-empty) and returns a ready-to-transmit flag that gates when the capture side dumps its accumulator. Each record is: header byte, word-count byte, payload (high byte then low byte per word), 8-bit checksum.

---
 rtl/acc_record_transmitter_if.sv | 44 ++++
 rtl/acc_record_transmitter.sv | 146 ++++++++++++++
 tb/tb_acc_record_transmitter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_record_transmitter_if.sv
// Handshake bundle between the record transmitter, the capture-side FIFO read port
// and the host byte link.
interface acc_record_transmitter_if;
    logic        start;
    logic        ready_to_transmit;
    logic        busy;
    logic        done;
    logic        fifo_not_empty;
    logic        fifo_rd;
    logic        fifo_valid;
    logic [15:0] fifo_dout;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;

    // master is the transmitter; slave is the capture side, FIFO and byte link
    modport master (
        input  start,
        input  fifo_not_empty,
        input  fifo_valid,
        input  fifo_dout,
        input  tx_ready,
        output ready_to_transmit,
        output busy,
        output done,
        output fifo_rd,
        output tx_byte,
        output tx_valid
    );

    modport slave (
        output start,
        output fifo_not_empty,
        output fifo_valid,
        output fifo_dout,
        output tx_ready,
        input  ready_to_transmit,
        input  busy,
        input  done,
        input  fifo_rd,
        input  tx_byte,
        input  tx_valid
    );
endinterface

// File: rtl/acc_record_transmitter.sv
// Pulls 16-bit histogram words from the capture FIFO and emits framed byte records:
// header, word count, payload (high byte first), 8-bit checksum of count and payload.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for start; ready_to_transmit high
//   SEND_HDR  | presenting HEADER_BYTE on the byte link
//   SEND_CNT  | presenting the word-count byte
//   FETCH     | issuing one FIFO read once the FIFO is not empty
//   WAIT_DATA | waiting for fifo_valid to capture the word
//   SEND_HI   | presenting word[15:8]
//   SEND_LO   | presenting word[7:0]; last word leads to SEND_SUM
//   SEND_SUM  | presenting the running checksum
//   DONE      | one-cycle done pulse, then back to IDLE
module acc_record_transmitter #(
    parameter int         WORDS_PER_RECORD = 128,
    parameter logic [7:0] HEADER_BYTE      = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    acc_record_transmitter_if.master  bus
);

    localparam logic [7:0] COUNT_BYTE = 8'(WORDS_PER_RECORD);
    localparam logic [7:0] LAST_WORD  = 8'(WORDS_PER_RECORD - 1);

    typedef enum logic [3:0] {
        IDLE,
        SEND_HDR,
        SEND_CNT,
        FETCH,
        WAIT_DATA,
        SEND_HI,
        SEND_LO,
        SEND_SUM,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] word;
    logic [7:0]  checksum;
    logic [7:0]  wordCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            word                  <= 16'h0000;
            checksum              <= 8'h00;
            wordCount             <= 8'h00;
            bus.tx_valid          <= 1'b0;
            bus.tx_byte           <= 8'h00;
            bus.fifo_rd           <= 1'b0;
            bus.done              <= 1'b0;
            bus.busy              <= 1'b0;
            bus.ready_to_transmit <= 1'b1;
        end else begin
            bus.done    <= 1'b0;
            bus.fifo_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state                 <= SEND_HDR;
                        wordCount             <= 8'h00;
                        checksum              <= 8'h00;
                        bus.tx_valid          <= 1'b1;
                        bus.tx_byte           <= HEADER_BYTE;
                        bus.busy              <= 1'b1;
                        bus.ready_to_transmit <= 1'b0;
                    end
                end
                SEND_HDR: begin
                    if (bus.tx_ready) begin
                        state       <= SEND_CNT;
                        bus.tx_byte <= COUNT_BYTE;
                    end
                end
                SEND_CNT: begin
                    if (bus.tx_ready) begin
                        state        <= FETCH;
                        checksum     <= checksum + COUNT_BYTE;
                        bus.tx_valid <= 1'b0;
                        bus.fifo_rd  <= bus.fifo_not_empty;
                    end
                end
                // fifo_rd is registered, so the read is launched on the edge that enters
                // or stays in FETCH; only this block pops the FIFO, so not-empty cannot fall.
                FETCH: begin
                    if (bus.fifo_rd) begin
                        state <= WAIT_DATA;
                    end else begin
                        bus.fifo_rd <= bus.fifo_not_empty;
                    end
                end
                WAIT_DATA: begin
                    if (bus.fifo_valid) begin
                        state        <= SEND_HI;
                        word         <= bus.fifo_dout;
                        bus.tx_valid <= 1'b1;
                        bus.tx_byte  <= bus.fifo_dout[15:8];
                    end
                end
                SEND_HI: begin
                    if (bus.tx_ready) begin
                        state       <= SEND_LO;
                        checksum    <= checksum + word[15:8];
                        bus.tx_byte <= word[7:0];
                    end
                end
                SEND_LO: begin
                    if (bus.tx_ready) begin
                        checksum  <= checksum + word[7:0];
                        wordCount <= wordCount + 8'd1;
                        if (wordCount == LAST_WORD) begin
                            state       <= SEND_SUM;
                            bus.tx_byte <= checksum + word[7:0];
                        end else begin
                            state        <= FETCH;
                            bus.tx_valid <= 1'b0;
                            bus.fifo_rd  <= bus.fifo_not_empty;
                        end
                    end
                end
                SEND_SUM: begin
                    if (bus.tx_ready) begin
                        state        <= DONE;
                        bus.tx_valid <= 1'b0;
                        bus.tx_byte  <= 8'h00;
                        bus.done     <= 1'b1;
                    end
                end
                DONE: begin
                    state                 <= IDLE;
                    bus.busy              <= 1'b0;
                    bus.ready_to_transmit <= 1'b1;
                end
                default: begin
                    state                 <= IDLE;
                    bus.tx_valid          <= 1'b0;
                    bus.busy              <= 1'b0;
                    bus.ready_to_transmit <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_record_transmitter.sv
// Randomised bench for acc_record_transmitter: three instances (4, 2 and 128 words per
// record) share a behavioural FIFO and a byte-queue scoreboard built from the framing rules.
module tb_acc_record_transmitter;

    logic       clk       = 1'b0;
    logic       tbRst     = 1'b1;
    logic       startReq  = 1'b0;
    logic       txReady   = 1'b1;
    logic [1:0] sel       = 2'd0;
    int         readyMode = 0;
    int         cyc       = 0;
    int         errors    = 0;
    int         checks    = 0;

    logic        fifoNotEmpty = 1'b0;
    logic        fifoValid    = 1'b0;
    logic [15:0] fifoDout     = 16'h0000;
    logic [15:0] fifoQ[$];
    logic [15:0] pushQ[$];
    logic [15:0] recWords[$];
    logic [7:0]  expQ[$];
    logic [7:0]  rxQ[$];
    logic [7:0]  expSum;

    int rdCount = 0, doneCount = 0;
    int firstByteCyc = 0, firstRdCyc = 0, doneCyc = 0, idleCyc = 0, startCyc = 0;
    logic       prevStall = 1'b0;
    logic       prevRtt   = 1'b1;
    logic [7:0] prevByte  = 8'h00;

    logic [7:0] lit4 [11] = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
                              8'h05, 8'h06, 8'h07, 8'h08, 8'h28};
    logic [7:0] lit2 [7]  = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    acc_record_transmitter_if ifA ();
    acc_record_transmitter_if ifB ();
    acc_record_transmitter_if ifC ();

    acc_record_transmitter #(.WORDS_PER_RECORD(4))   dutA (.clk(clk), .rst(tbRst), .bus(ifA));
    acc_record_transmitter #(.WORDS_PER_RECORD(2))   dutB (.clk(clk), .rst(tbRst), .bus(ifB));
    acc_record_transmitter #(.WORDS_PER_RECORD(128)) dutC (.clk(clk), .rst(tbRst), .bus(ifC));

    assign ifA.start = startReq && (sel == 2'd0);
    assign ifB.start = startReq && (sel == 2'd1);
    assign ifC.start = startReq && (sel == 2'd2);
    assign ifA.tx_ready = txReady;
    assign ifB.tx_ready = txReady;
    assign ifC.tx_ready = txReady;
    assign ifA.fifo_not_empty = fifoNotEmpty;
    assign ifB.fifo_not_empty = fifoNotEmpty;
    assign ifC.fifo_not_empty = fifoNotEmpty;
    assign ifA.fifo_valid = fifoValid;
    assign ifB.fifo_valid = fifoValid;
    assign ifC.fifo_valid = fifoValid;
    assign ifA.fifo_dout = fifoDout;
    assign ifB.fifo_dout = fifoDout;
    assign ifC.fifo_dout = fifoDout;

    logic [3:0] vValid, vRd, vDone, vBusy, vRtt;
    logic [7:0] vByte [4];
    assign vValid = {1'b0, ifC.tx_valid, ifB.tx_valid, ifA.tx_valid};
    assign vRd    = {1'b0, ifC.fifo_rd, ifB.fifo_rd, ifA.fifo_rd};
    assign vDone  = {1'b0, ifC.done, ifB.done, ifA.done};
    assign vBusy  = {1'b0, ifC.busy, ifB.busy, ifA.busy};
    assign vRtt   = {1'b0, ifC.ready_to_transmit, ifB.ready_to_transmit, ifA.ready_to_transmit};
    assign vByte[0] = ifA.tx_byte;
    assign vByte[1] = ifB.tx_byte;
    assign vByte[2] = ifC.tx_byte;
    assign vByte[3] = 8'h00;

    logic       obsValid, obsFifoRd, obsDone, obsBusy, obsRtt;
    logic [7:0] obsByte;
    assign obsValid  = vValid[sel];
    assign obsFifoRd = vRd[sel];
    assign obsDone   = vDone[sel];
    assign obsBusy   = vBusy[sel];
    assign obsRtt    = vRtt[sel];
    assign obsByte   = vByte[sel];

    // FIFO: read data and valid appear the cycle after the read strobe
    always @(posedge clk) begin
        if (tbRst) begin
            fifoQ.delete();
            pushQ.delete();
            fifoValid <= 1'b0;
        end else begin
            if (obsFifoRd && fifoQ.size() > 0) begin
                fifoDout  <= fifoQ.pop_front();
                fifoValid <= 1'b1;
            end else begin
                fifoValid <= 1'b0;
            end
            while (pushQ.size() > 0) fifoQ.push_back(pushQ.pop_front());
        end
        fifoNotEmpty <= (fifoQ.size() != 0);
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (readyMode)
            1:       txReady = ~txReady;
            2:       txReady = 1'($urandom_range(0, 1));
            default: txReady = 1'b1;
        endcase
    end

    // per-cycle compare against the expected byte stream and protocol rules
    initial forever begin
        @(negedge clk);
        if (tbRst) begin
            prevStall = 1'b0;
            prevRtt   = 1'b1;
        end else begin
            if (obsValid && txReady) begin
                if (rxQ.size() == 0) firstByteCyc = cyc;
                rxQ.push_back(obsByte);
                check(expQ.size() > 0, "extra_byte", obsByte, 0);
                if (expQ.size() > 0) begin
                    check(obsByte == expQ[0], "tx_byte", obsByte, expQ[0]);
                    void'(expQ.pop_front());
                end
            end
            if (prevStall)
                check(obsValid && obsByte == prevByte, "stall_hold", obsByte, prevByte);
            prevStall = obsValid && !txReady;
            prevByte  = obsByte;
            check(obsRtt == !obsBusy, "rtt_vs_busy", obsRtt, !obsBusy);
            if (obsFifoRd) begin
                check(fifoNotEmpty, "rd_when_empty", fifoNotEmpty, 1);
                if (rdCount == 0) firstRdCyc = cyc;
                rdCount++;
            end
            if (obsDone) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (obsRtt && !prevRtt) idleCyc = cyc;
            prevRtt = obsRtt;
        end
    end

    task automatic clearRun();
        rxQ.delete();
        expQ.delete();
        recWords.delete();
        rdCount = 0;
    endtask

    task automatic pushWords(input int from, input int upto);
        for (int i = from; i < upto; i++) pushQ.push_back(recWords[i]);
    endtask

    task automatic expectRecord(input int n);
        int sum;
        sum = n;
        expQ.push_back(8'hA5);
        expQ.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            expQ.push_back(recWords[i][15:8]);
            expQ.push_back(recWords[i][7:0]);
            sum = sum + int'(recWords[i][15:8]) + int'(recWords[i][7:0]);
        end
        expSum = 8'(sum % 256);
        expQ.push_back(expSum);
    endtask

    task automatic randomWords(input int n);
        for (int i = 0; i < n; i++) recWords.push_back(16'($urandom));
    endtask

    task automatic startRecord();
        @(posedge clk);
        #1;
        startReq = 1'b1;
        startCyc = cyc;
        @(posedge clk);
        #1;
        startReq = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int d0 = doneCount;
        int n  = 0;
        while (doneCount == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(doneCount != d0, "done_timeout", n, budget);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int n;

        // reset values on every instance
        tbRst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            check(obsValid == 1'b0 && obsByte == 8'h00, "rst_tx", {obsValid, obsByte}, 0);
            check(obsFifoRd == 1'b0 && obsDone == 1'b0, "rst_rd_done", {obsFifoRd, obsDone}, 0);
            check(obsBusy == 1'b0 && obsRtt == 1'b1, "rst_busy_rtt", {obsBusy, obsRtt}, 1);
        end
        sel = 2'd0;
        @(posedge clk);
        #1;
        tbRst = 1'b0;

        // four fixed words, link always ready: exact bytes and cycle positions
        clearRun();
        readyMode = 0;
        recWords = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        pushWords(0, 4);
        expectRecord(4);
        check(expSum == 8'h28, "model_sum_n4", expSum, 8'h28);
        startRecord();
        waitDone(200);
        check(rxQ.size() == 11, "rec4_len", rxQ.size(), 11);
        for (int i = 0; i < 11; i++)
            check(rxQ.size() > i && rxQ[i] == lit4[i], "rec4_byte", rxQ[i], lit4[i]);
        check(firstByteCyc - startCyc == 1, "hdr_cycle", firstByteCyc - startCyc, 1);
        check(firstRdCyc - startCyc == 3, "first_rd_cycle", firstRdCyc - startCyc, 3);
        check(doneCyc - startCyc == 2 + 4 * 4 + 2, "done_cycle", doneCyc - startCyc, 20);
        check(idleCyc == doneCyc + 1, "idle_cycle", idleCyc - doneCyc, 1);
        check(rdCount == 4, "rd_count4", rdCount, 4);

        // same record with alternating link backpressure
        clearRun();
        readyMode = 1;
        recWords = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        pushWords(0, 4);
        expectRecord(4);
        startRecord();
        waitDone(400);
        check(rxQ.size() == 11, "alt_len", rxQ.size(), 11);
        for (int i = 0; i < 11; i++)
            check(rxQ.size() > i && rxQ[i] == lit4[i], "alt_byte", rxQ[i], lit4[i]);

        // FIFO runs dry after two words; remaining two arrive later
        clearRun();
        readyMode = 0;
        randomWords(4);
        pushWords(0, 2);
        expectRecord(4);
        d0 = doneCount;
        startRecord();
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        check(obsBusy && !obsValid && !obsFifoRd, "starved_hold", {obsBusy, obsValid, obsFifoRd}, 4);
        check(rxQ.size() == 6, "starved_bytes", rxQ.size(), 6);
        check(doneCount == d0, "starved_no_done", doneCount, d0);
        pushWords(2, 4);
        waitDone(200);
        check(rxQ.size() == 11 && expQ.size() == 0, "starved_complete", rxQ.size(), 11);
        check(rdCount == 4, "starved_rd_count", rdCount, 4);

        // two all-ones words: checksum wraps
        clearRun();
        sel = 2'd1;
        readyMode = 0;
        recWords = '{16'hFFFF, 16'hFFFF};
        pushWords(0, 2);
        expectRecord(2);
        check(expSum == 8'hFE, "model_sum_wrap", expSum, 8'hFE);
        startRecord();
        waitDone(200);
        check(rxQ.size() == 7, "wrap_len", rxQ.size(), 7);
        for (int i = 0; i < 7; i++)
            check(rxQ.size() > i && rxQ[i] == lit2[i], "wrap_byte", rxQ[i], lit2[i]);

        // extra start pulses while busy are ignored
        clearRun();
        sel = 2'd0;
        readyMode = 2;
        randomWords(4);
        pushWords(0, 4);
        expectRecord(4);
        d0 = doneCount;
        startRecord();
        repeat (3) begin
            @(posedge clk);
            #1;
            startReq = 1'b1;
            @(posedge clk);
            #1;
            startReq = 1'b0;
        end
        waitDone(400);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check(doneCount == d0 + 1, "busy_start_ignored", doneCount, d0 + 1);
        check(rxQ.size() == 11 && !obsBusy, "busy_start_len", rxQ.size(), 11);

        // reset after the third byte abandons the record
        clearRun();
        readyMode = 0;
        randomWords(4);
        pushWords(0, 4);
        expectRecord(4);
        startRecord();
        n = 0;
        while (rxQ.size() < 3 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(rxQ.size() >= 3, "pre_reset_bytes", rxQ.size(), 3);
        tbRst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(!obsValid && obsRtt && !obsBusy && !obsFifoRd, "mid_reset",
              {obsValid, obsRtt, obsBusy, obsFifoRd}, 4'b0100);
        @(posedge clk);
        #1;
        tbRst = 1'b0;
        clearRun();
        readyMode = 1;
        randomWords(4);
        pushWords(0, 4);
        expectRecord(4);
        startRecord();
        waitDone(400);
        check(rxQ.size() == 11 && rxQ[0] == 8'hA5, "fresh_after_reset", rxQ.size(), 11);
        check(expQ.size() == 0, "fresh_all_sent", expQ.size(), 0);

        // default length, ramp payload, random backpressure
        clearRun();
        sel = 2'd2;
        readyMode = 2;
        for (int i = 0; i < 128; i++) recWords.push_back(16'(i));
        pushWords(0, 128);
        expectRecord(128);
        check(expSum == 8'h40, "model_sum_ramp", expSum, 8'h40);
        startRecord();
        waitDone(4000);
        check(rxQ.size() == 259, "ramp_len", rxQ.size(), 259);
        check(rxQ.size() > 1 && rxQ[1] == 8'h80, "ramp_count_byte", rxQ[1], 8'h80);
        check(rxQ.size() == 259 && rxQ[258] == expSum, "ramp_checksum", rxQ[258], expSum);
        check(rdCount == 128, "ramp_rd_count", rdCount, 128);
        check(expQ.size() == 0, "ramp_all_sent", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
